// File: rtl/y86_instr_writer.sv
// Byte-serial Y86-64 instruction encoder: takes one decoded instruction per
// handshake and writes its fetch-compatible byte image into instruction memory.
module y86_instr_writer #(
    parameter int ADDR_W    = 10,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_base,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] wptr,
    output logic [15:0]       instr_count,
    output logic              err_ill,
    output logic              err_ovf
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    // Encoded length in bytes; zero marks an icode the processor cannot decode.
    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        logic [3:0] len;
        case (ic)
            4'h0, 4'h1, 4'h9:       len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
            4'h7, 4'h8:             len = 4'd9;
            4'h3, 4'h4, 4'h5:       len = 4'd10;
            default:                len = 4'd0;
        endcase
        return len;
    endfunction

    // k = 0 selects the most significant byte of valC.
    function automatic logic [7:0] valc_byte(input logic [63:0] v, input logic [2:0] k);
        logic [63:0] shifted;
        shifted = v << {k, 3'b000};
        return shifted[63:56];
    endfunction

    function automatic logic [7:0] enc_byte(
        input logic [3:0]  ic,
        input logic [3:0]  fn,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [63:0] v,
        input logic [3:0]  len,
        input logic [3:0]  idx
    );
        logic [7:0] res;
        if (idx == 4'd0) begin
            res = {ic, fn};
        end else if ((len == 4'd2) || ((len == 4'd10) && (idx == 4'd1))) begin
            res = {ra, rb};
        end else if (len == 4'd10) begin
            res = valc_byte(v, 3'(idx - 4'd2));
        end else if (len == 4'd9) begin
            res = valc_byte(v, 3'(idx - 4'd1));
        end else begin
            res = 8'h00;
        end
        return res;
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        icode_q, icode_d;
    logic [3:0]        ifun_q, ifun_d;
    logic [3:0]        ra_q, ra_d;
    logic [3:0]        rb_q, rb_d;
    logic [63:0]       valc_q, valc_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [15:0]       count_q, count_d;
    logic              ill_q, ill_d;
    logic              ovf_q, ovf_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic [3:0]        offer_len_s;
    logic [ADDR_W:0]   offer_end_s;

    assign in_ready    = (state_q == ST_IDLE) && !set_base;
    assign offer_len_s = instr_len(icode);
    // One bit wider than the pointer so an instruction ending exactly at MEM_BYTES still fits.
    assign offer_end_s = {1'b0, wptr_q} + (ADDR_W+1)'(offer_len_s);

    // Next-state logic for the IDLE/EMIT sequencer, pointer, counters and strobe.
    always_comb begin
        state_d     = state_q;
        icode_d     = icode_q;
        ifun_d      = ifun_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        valc_d      = valc_q;
        len_d       = len_q;
        idx_d       = idx_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        ill_d       = ill_q;
        ovf_d       = ovf_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (set_base) begin
                    wptr_d = base_addr;
                    ill_d  = 1'b0;
                    ovf_d  = 1'b0;
                end else if (in_valid) begin
                    if (offer_len_s == 4'd0) begin
                        ill_d = 1'b1;
                    end else if (offer_end_s > MEM_LIMIT) begin
                        ovf_d = 1'b1;
                    end else begin
                        icode_d = icode;
                        ifun_d  = ifun;
                        ra_d    = rA;
                        rb_d    = rB;
                        valc_d  = valC;
                        len_d   = offer_len_s;
                        idx_d   = 4'd0;
                        state_d = ST_EMIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = wptr_q;
                mem_wdata_d = enc_byte(icode_q, ifun_q, ra_q, rb_q, valc_q, len_q, idx_q);
                wptr_d      = wptr_q + ADDR_W'(1);
                idx_d       = idx_q + 4'd1;
                if (idx_q == (len_q - 4'd1)) begin
                    count_d = count_q + 16'd1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            icode_q     <= 4'h0;
            ifun_q      <= 4'h0;
            ra_q        <= 4'h0;
            rb_q        <= 4'h0;
            valc_q      <= 64'h0;
            len_q       <= 4'd0;
            idx_q       <= 4'd0;
            wptr_q      <= '0;
            count_q     <= 16'd0;
            ill_q       <= 1'b0;
            ovf_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            icode_q     <= icode_d;
            ifun_q      <= ifun_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            valc_q      <= valc_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            ill_q       <= ill_d;
            ovf_q       <= ovf_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wptr        = wptr_q;
    assign instr_count = count_q;
    assign err_ill     = ill_q;
    assign err_ovf     = ovf_q;

endmodule

// File: tb/tb_y86_instr_writer.sv
// Directed bench for y86_instr_writer: a byte-image model predicts every memory
// write, a per-cycle monitor checks the strobes, and literal tables pin the model.
module tb_y86_instr_writer;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          set_base;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    icode, ifun, rA, rB;
    logic [63:0]   valC;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [AW-1:0] wptr;
    logic [15:0]   instr_count;
    logic          err_ill, err_ovf;

    always #5 clk = ~clk;

    y86_instr_writer #(.ADDR_W(AW), .MEM_BYTES(1024)) dut (
        .clk(clk), .reset(reset), .set_base(set_base), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .icode(icode), .ifun(ifun),
        .rA(rA), .rB(rB), .valC(valC), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .wptr(wptr), .instr_count(instr_count),
        .err_ill(err_ill), .err_ovf(err_ovf)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [7:0]    mem [0:1023];
    logic [AW-1:0] m_wptr;
    logic [15:0]   m_count;
    logic          m_ill, m_ovf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int spec_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 0;
        endcase
    endfunction

    // Predicted byte image of one instruction starting at address a0.
    task automatic push_image(input logic [AW-1:0] a0, input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc);
        int            len;
        logic [AW-1:0] a;
        len = spec_len(ic);
        a   = a0;
        exp_q.push_back({a, ic, fn});
        a = a + AW'(1);
        if (len == 2 || len == 10) begin
            exp_q.push_back({a, ra, rb});
            a = a + AW'(1);
        end
        if (len >= 9) begin
            for (int i = 7; i >= 0; i--) begin
                exp_q.push_back({a, vc[8*i +: 8]});
                a = a + AW'(1);
            end
        end
    endtask

    // Every strobe must be the next predicted byte; no strobe may appear unpredicted.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            mem[mem_addr] = mem_wdata;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_write actual=addr %0d data %0h required=no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(mon_e.a));
                chk("wr_data", 64'(mem_wdata), 64'(mon_e.d));
                chk("wptr_lead", 64'(wptr), 64'(AW'(mon_e.a + AW'(1))));
            end
        end
    end

    task automatic check_model();
        chk("wptr", 64'(wptr), 64'(m_wptr));
        chk("instr_count", 64'(instr_count), 64'(m_count));
        chk("err_ill", 64'(err_ill), 64'(m_ill));
        chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
        chk("bytes_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc);
        int n;
        int len;
        bit fits;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout actual=%b required=1", in_ready);
        end
        icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
        in_valid = 1'b1;
        len  = spec_len(ic);
        fits = (len != 0) && (int'(m_wptr) + len <= 1024);
        if (fits) push_image(m_wptr, ic, fn, ra, rb, vc);
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (len == 0) begin
            m_ill = 1'b1;
        end else if (!fits) begin
            m_ovf = 1'b1;
        end else begin
            m_wptr  = AW'(int'(m_wptr) + len);
            m_count = m_count + 16'd1;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                chk("ready_busy", 64'(in_ready), 64'd0);
            end
        end
        @(negedge clk);
        chk("ready_back", 64'(in_ready), 64'd1);
        #1 check_model();
    endtask

    task automatic set_base_to(input logic [AW-1:0] b);
        @(negedge clk);
        set_base = 1'b1;
        base_addr = b;
        #1 chk("ready_setbase", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 set_base = 1'b0;
        m_wptr = b; m_ill = 1'b0; m_ovf = 1'b0;
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        m_wptr = '0; m_count = 16'd0; m_ill = 1'b0; m_ovf = 1'b0;
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        check_model();
        reset = 1'b0;
    endtask

    logic [7:0] t1 [0:9];
    logic [7:0] t2 [0:14];
    logic [7:0] t3 [0:9];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t1 = '{8'h30, 8'hF3, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        t2 = '{8'h20, 8'h13, 8'h60, 8'h24, 8'h70, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 8'h90, 8'h00};
        t3 = '{8'h40, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
        reset = 1'b1; set_base = 1'b0; base_addr = '0; in_valid = 1'b0;
        icode = 4'h0; ifun = 4'h0; rA = 4'h0; rB = 4'h0; valC = 64'h0;
        m_wptr = '0; m_count = 16'd0; m_ill = 1'b0; m_ovf = 1'b0;
        do_reset();

        // irmovq at base 0
        send(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF);
        for (int i = 0; i < 10; i++) chk("irmovq_image", 64'(mem[i]), 64'(t1[i]));
        chk("irmovq_wptr", 64'(wptr), 64'd10);
        chk("irmovq_count", 64'(instr_count), 64'd1);

        // back-to-back stream
        do_reset();
        send(4'h2, 4'h0, 4'h1, 4'h3, 64'h0);
        send(4'h6, 4'h0, 4'h2, 4'h4, 64'h0);
        send(4'h7, 4'h0, 4'hF, 4'hF, 64'h22);
        send(4'h9, 4'h0, 4'hF, 4'hF, 64'hDEAD);
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
        for (int i = 0; i < 15; i++) chk("stream_image", 64'(mem[i]), 64'(t2[i]));
        chk("stream_count", 64'(instr_count), 64'd5);
        chk("stream_wptr", 64'(wptr), 64'd15);

        // overflow, then exact fit at the top of memory
        set_base_to(AW'(1020));
        send(4'h4, 4'h0, 4'h1, 4'h2, 64'h10);
        chk("ovf_flag", 64'(err_ovf), 64'd1);
        chk("ovf_wptr", 64'(wptr), 64'd1020);
        set_base_to(AW'(1014));
        chk("ovf_cleared", 64'(err_ovf), 64'd0);
        send(4'h4, 4'h0, 4'h1, 4'h2, 64'h10);
        for (int i = 0; i < 10; i++) chk("top_image", 64'(mem[1014+i]), 64'(t3[i]));
        chk("top_wrap_wptr", 64'(wptr), 64'd0);

        // illegal icode, then nop at the unchanged pointer
        set_base_to(AW'(200));
        send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0);
        chk("ill_flag", 64'(err_ill), 64'd1);
        chk("ill_wptr", 64'(wptr), 64'd200);
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
        chk("nop_byte", 64'(mem[200]), 64'h10);
        chk("nop_wptr", 64'(wptr), 64'd201);

        // set_base together with in_valid: pointer loads, instruction waits a cycle
        @(negedge clk);
        set_base = 1'b1; base_addr = AW'(300);
        icode = 4'h1; ifun = 4'h0; rA = 4'h0; rB = 4'h0; valC = 64'h0; in_valid = 1'b1;
        #1 chk("sb_iv_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 set_base = 1'b0;
        m_wptr = AW'(300); m_ill = 1'b0; m_ovf = 1'b0;
        chk("sb_iv_wptr", 64'(wptr), 64'd300);
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
        chk("sb_iv_byte", 64'(mem[300]), 64'h10);

        // reset in the middle of a call
        set_base_to(AW'(40));
        @(negedge clk);
        icode = 4'h8; ifun = 4'h0; rA = 4'hF; rB = 4'hF; valC = 64'h35; in_valid = 1'b1;
        push_image(m_wptr, 4'h8, 4'h0, 4'hF, 4'hF, 64'h35);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        m_wptr = '0; m_count = 16'd0; m_ill = 1'b0; m_ovf = 1'b0;
        chk("midrst_mem_we", 64'(mem_we), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        check_model();
        reset = 1'b0;
        chk("midrst_b40", 64'(mem[40]), 64'h80);
        chk("midrst_b41", 64'(mem[41]), 64'h00);
        chk("midrst_b42", 64'(mem[42]), 64'h00);
        chk("midrst_b43", 64'(mem[43]), 64'hEE);
        repeat (3) @(negedge clk);
        chk("idle_after_rst", 64'(wptr), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/y86_instr_writer.md
# y86_instr_writer

Byte-serial instruction encoder/loader for the Y86-64 SEQ processor; the write-side counterpart of the fetch stage. Accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake and writes its encoded bytes, one per cycle, into the byte-wide instruction memory at a running write pointer. The byte layout matches exactly what fetch decodes: the instruction memory is filled by a testbench or boot loader, and the fetch stage then reads the same bytes back.

## Interface
- ADDR_W, 10, byte-address width of instruction memory
- MEM_BYTES, 1024, instruction memory size in bytes
- clk  in  1  clock; everything is on posedge
- reset  in  1  synchronous, active-high
- set_base  in  1  load write pointer from base_addr; honoured only in IDLE
- base_addr  in  ADDR_W  new write pointer value
- in_valid  in  1  instruction fields valid
- in_ready  out  1  combinational, equals (state==IDLE) && !set_base
- icode, ifun, rA, rB  in  4 each  instruction fields
- valC  in  64  constant, displacement, or destination
- mem_we  out  1  registered byte-write strobe
- mem_addr  out  ADDR_W  registered byte address
- mem_wdata  out  8  registered byte data
- wptr  out  ADDR_W  address of the next byte to write
- instr_count  out  16  instructions fully written, wraps at 0xFFFF→0
- err_ill  out  1  sticky: an illegal icode (>0xB) was offered
- err_ovf  out  1  sticky: an instruction would not have fit in memory

## Operation
- Length by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte
  - 2 cmovxx, 6 OPq, A pushq, B popq: 2 bytes
  - 7 jxx, 8 call: 9 bytes
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes
- Byte 0 is {icode,ifun}.
- Register forms: byte 1 is {rA,rB}, written verbatim with no F-substitution.
- valC is big-endian, MS byte first: bytes 2..9 (len 10) or bytes 1..8 (len 9) carry valC[63:56] down to valC[7:0].
- ret writes only its opcode byte; valC is ignored.
- FSM states: IDLE, EMIT.
- IDLE:
  - set_base=1: wptr←base_addr, err_ill←0, err_ovf←0. in_valid is not accepted that cycle.
  - Accept (in_valid && in_ready) with icode>0xB: err_ill←1, no write, stay in IDLE.
  - Accept with wptr+len > MEM_BYTES (computed at ADDR_W+1 bits): err_ovf←1, no write, wptr unchanged, stay in IDLE. There are no partial writes.
  - Otherwise: latch the fields, idx←0, go to EMIT.
- EMIT, per cycle:
  - Register mem_we=1, mem_addr=wptr, mem_wdata=byte[idx].
  - wptr←wptr+1, idx←idx+1.
  - On the last byte: instr_count←instr_count+1, go to IDLE.
- set_base and in_valid are ignored in EMIT. in_valid must be held until accepted.
- reset: state←IDLE. mem_we, mem_addr, mem_wdata, wptr, instr_count, err_ill, err_ovf all ←0. The latched instruction is discarded.
  - Reset mid-EMIT aborts the instruction; bytes already written stay in memory.

## Timing
- Accept at edge N → first byte strobe visible after edge N+1; last byte after edge N+len.
- in_ready is low for len cycles after accept, then high again. Peak throughput is one instruction per len+1 cycles.
- mem_we is low in every cycle where no byte is emitted, including after rejected offers.
- wptr and the mem_* outputs update on the same edge. During the strobe cycle, wptr already equals mem_addr+1.
- An instruction that ends exactly at MEM_BYTES (e.g. 10 bytes from 1014) is legal. wptr then wraps to 0 and is still a legal address.

## Test plan
- Reset, then irmovq: icode=3, ifun=0, rA=F, rB=3, valC=0x0123456789ABCDEF at base 0 → addrs 0..9 get 30 F3 01 23 45 67 89 AB CD EF on 10 consecutive cycles; wptr=10, instr_count=1.
- Back-to-back stream, each offered as soon as in_ready returns:
  - stimulus: cmovxx 2/0 rA=1 rB=3, then OPq 6/0 rA=2 rB=4, then jxx 7/0 valC=0x22, then ret 9/0, then halt
  - response: bytes 20 13 60 24 70 00 00 00 00 00 00 00 22 90 00 at addrs 0..14; instr_count=5; in_ready low exactly len cycles after each accept.
- Overflow: set_base 1020, then rmmovq → err_ovf=1, mem_we never high, wptr=1020. Then set_base 1014 and rmmovq → err_ovf cleared, 10 bytes written at 1014..1023, wptr=0.
- Illegal: icode=0xC offered → accepted in one cycle, err_ill=1, no write. A following nop writes 10 at the unchanged wptr.
- Reset mid-op: call 8/0 valC=0x35 at base 40; assert reset after 3 bytes → next cycle mem_we=0, wptr=0, instr_count=0, in_ready=1; addrs 40..42 hold 80 00 00.
- set_base asserted together with in_valid in IDLE → in_ready=0, pointer loads, instruction accepted on the following cycle.
